flag_sched: RTL and testbench

- Controls the N/V/Z condition-flag state for the pipelined CPU.
- Holds the architectural flags and writes them per bit when flag-producing ALU ops complete.
- Tracks how many flag writes are in flight for each flag bit.
- Resolves branch condition codes and stalls branches in decode until every flag they read is settled, forwarding a completing write where legal.

---
 rtl/flag_sched.sv | 136 +++++++++++++
 tb/tb_flag_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_sched.sv
// flag_sched: N/V/Z condition-flag scoreboard for the pipelined CPU.
// Keeps the architectural flags, counts in-flight flag writers per bit, and
// resolves decode-stage branches (stalling or forwarding from EX as needed).
// Flag bit order everywhere is {N,V,Z} = bits [2:0].
module flag_sched #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_is_branch,
  input  logic [2:0] id_ccc,
  input  logic [2:0] id_sets,
  input  logic       flush,
  input  logic       ex_wr,
  input  logic [2:0] ex_mask,
  input  logic [2:0] ex_flags,
  output logic [2:0] flags,
  output logic       stall,
  output logic       br_valid,
  output logic       br_taken
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [2:0]       flags_q, flags_d;
  logic             br_valid_q, br_taken_q;
  logic [CNT_W-1:0] pend_q [3];
  logic [CNT_W-1:0] pend_d [3];

  logic [2:0] inc, dec;
  logic [2:0] pend_zero, pend_one, pend_full;
  logic [2:0] resolved, eff, need;
  logic       issue, resolve, taken;
  logic       stall_br, stall_full;

  // Per-bit pending counter and its resolution status for this cycle.
  for (genvar gi = 0; gi < 3; gi++) begin : g_bit
    assign inc[gi]       = issue & id_sets[gi];
    assign dec[gi]       = ex_wr & ex_mask[gi];
    assign pend_zero[gi] = (pend_q[gi] == '0);
    assign pend_one[gi]  = (pend_q[gi] == ONE_CNT);
    assign pend_full[gi] = (pend_q[gi] == MAX_CNT);
    // Settled if nothing is in flight, or the only writer completes right now.
    assign resolved[gi]  = pend_zero[gi] | (pend_one[gi] & dec[gi]);
    assign eff[gi]       = pend_zero[gi] ? flags_q[gi] : ex_flags[gi];

    // Next count: flush clears, inc+dec cancel, decrement saturates at zero.
    always_comb begin
      pend_d[gi] = pend_q[gi];
      if (flush) begin
        pend_d[gi] = '0;
      end else if (inc[gi] && !dec[gi]) begin
        pend_d[gi] = pend_q[gi] + ONE_CNT;
      end else if (dec[gi] && !inc[gi] && !pend_zero[gi]) begin
        pend_d[gi] = pend_q[gi] - ONE_CNT;
      end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q[gi] <= '0;
      end else begin
        pend_q[gi] <= pend_d[gi];
      end
    end
  end

  // Which flags each condition code reads.
  always_comb begin
    need = 3'b000;
    case (id_ccc)
      3'd0:    need = 3'b001;  // NE
      3'd1:    need = 3'b001;  // EQ
      3'd2:    need = 3'b101;  // GT
      3'd3:    need = 3'b100;  // LT
      3'd4:    need = 3'b101;  // GE
      3'd5:    need = 3'b101;  // LE
      3'd6:    need = 3'b010;  // OV
      default: need = 3'b000;  // UN
    endcase
  end

  // Branch outcome from the effective (stored or forwarded) flags.
  always_comb begin
    taken = 1'b1;
    case (id_ccc)
      3'd0:    taken = ~eff[0];
      3'd1:    taken = eff[0];
      3'd2:    taken = ~eff[0] & ~eff[2];
      3'd3:    taken = eff[2];
      3'd4:    taken = eff[0] | ~eff[2];
      3'd5:    taken = eff[0] | eff[2];
      3'd6:    taken = eff[1];
      default: taken = 1'b1;
    endcase
  end

  assign stall_br   = id_is_branch & |(need & ~resolved);
  // A producer cannot issue into a full counter unless a slot frees this cycle.
  assign stall_full = |(id_sets & pend_full & ~dec);
  assign stall      = id_valid & ~flush & (stall_br | stall_full);
  assign issue      = id_valid & ~stall & ~flush;
  assign resolve    = issue & id_is_branch;

  // EX writes only the masked bits; flush never blocks a write already in EX.
  always_comb begin
    flags_d = flags_q;
    if (ex_wr) begin
      flags_d = (flags_q & ~ex_mask) | (ex_flags & ex_mask);
    end
  end

  // Architectural flags and registered branch result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q    <= 3'b000;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      br_valid_q <= resolve;
      if (resolve) begin
        br_taken_q <= taken;
      end
    end
  end

  assign flags    = flags_q;
  assign br_valid = br_valid_q;
  assign br_taken = br_taken_q;

endmodule

// File: tb/tb_flag_sched.sv
// tb_flag_sched: directed scenarios plus constrained-random traffic for
// flag_sched, checked every cycle against a behavioural flag/branch model.
module tb_flag_sched;

  localparam int MAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic       id_is_branch = 1'b0;
  logic [2:0] id_ccc = 3'b000;
  logic [2:0] id_sets = 3'b000;
  logic       flush = 1'b0;
  logic       ex_wr = 1'b0;
  logic [2:0] ex_mask = 3'b000;
  logic [2:0] ex_flags = 3'b000;
  logic [2:0] flags;
  logic       stall;
  logic       br_valid;
  logic       br_taken;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  flag_sched #(.MAX_INFLIGHT(MAX), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_ccc(id_ccc), .id_sets(id_sets), .flush(flush),
    .ex_wr(ex_wr), .ex_mask(ex_mask), .ex_flags(ex_flags),
    .flags(flags), .stall(stall), .br_valid(br_valid), .br_taken(br_taken)
  );

  // ---------------- behavioural model ----------------
  int       m_pend [3];
  bit [2:0] m_flags;
  bit       m_bv, m_bt;

  function automatic bit [2:0] needs(bit [2:0] ccc);
    case (ccc)
      3'd0, 3'd1:       return 3'b001;
      3'd2, 3'd4, 3'd5: return 3'b101;
      3'd3:             return 3'b100;
      3'd6:             return 3'b010;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic bit cond(bit [2:0] ccc, bit n, bit v, bit z);
    case (ccc)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return z || n;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit retiring(int i);
    return ex_wr && ex_mask[i];
  endfunction

  function automatic bit known(int i);
    return (m_pend[i] == 0) || (m_pend[i] == 1 && retiring(i));
  endfunction

  function automatic bit value(int i);
    return (m_pend[i] == 0) ? m_flags[i] : ex_flags[i];
  endfunction

  function automatic bit m_stall();
    bit [2:0] nd;
    bit blocked;
    if (!id_valid || flush) return 1'b0;
    nd = needs(id_ccc);
    blocked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (id_is_branch && nd[i] && !known(i)) blocked = 1'b1;
      if (id_sets[i] && m_pend[i] >= MAX && !retiring(i)) blocked = 1'b1;
    end
    return blocked;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_pend[i] = 0;
    m_flags = 3'b000;
    m_bv = 1'b0;
    m_bt = 1'b0;
  endtask

  task automatic model_step();
    bit s, go;
    bit n, v, z;
    s = m_stall();
    go = id_valid && !s && !flush;
    n = value(2);
    v = value(1);
    z = value(0);
    if (go && id_is_branch) begin
      m_bv = 1'b1;
      m_bt = cond(id_ccc, n, v, z);
    end else begin
      m_bv = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      int d, u;
      u = (go && id_sets[i]) ? 1 : 0;
      d = retiring(i) ? 1 : 0;
      if (d == 1 && m_pend[i] == 0) begin
        n_fail++;
        $display("FAIL protocol: retire of flag %0d with nothing pending at %0t", i, $time);
      end
      if (flush) m_pend[i] = 0;
      else       m_pend[i] = m_pend[i] + u - d;
      if (m_pend[i] < 0) m_pend[i] = 0;
      if (m_pend[i] > MAX) begin
        n_fail++;
        $display("FAIL protocol: flag %0d has %0d writers pending, limit %0d", i, m_pend[i], MAX);
      end
    end
    if (ex_wr) begin
      for (int i = 0; i < 3; i++) if (ex_mask[i]) m_flags[i] = ex_flags[i];
    end
  endtask

  // ---------------- helpers ----------------
  task automatic ck(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setin(bit v, bit br, bit [2:0] ccc, bit [2:0] sets,
                       bit fl, bit wr, bit [2:0] m, bit [2:0] f);
    id_valid = v; id_is_branch = br; id_ccc = ccc; id_sets = sets;
    flush = fl; ex_wr = wr; ex_mask = m; ex_flags = f;
  endtask

  task automatic idle();
    setin(0, 0, 3'd0, 3'b000, 0, 0, 3'b000, 3'b000);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    bit       prev_stall;
    bit [7:0] prev_id;
    prev_stall = 1'b0;
    prev_id = 8'h00;
    wait (chk_on);
    forever begin
      @(negedge clk);
      ck("stall", stall, m_stall());
      ck("flags", flags, m_flags);
      ck("br_valid", br_valid, m_bv);
      ck("br_taken", br_taken, m_bt);
      if (prev_stall)
        ck("decode_held", {id_valid, id_is_branch, id_ccc, id_sets}, prev_id);
      prev_stall = stall && !flush;
      prev_id = {id_valid, id_is_branch, id_ccc, id_sets};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit was_stall;
    idle();
    model_reset();
    #1 rst = 1'b1;
    model_reset();
    #1;
    ck("rst_flags", flags, 3'b000);
    ck("rst_bv", br_valid, 1'b0);
    ck("rst_stall", stall, 1'b0);
    chk_on = 1'b1;
    #8 rst = 1'b0;
    tick();

    // Forwarding: SUB sets all flags, EQ branch resolves off the EX write.
    setin(1, 0, 3'd0, 3'b111, 0, 0, 3'b000, 3'b000);
    #1 ck("fwd_issue_stall", stall, 1'b0);
    tick();
    setin(1, 1, 3'd1, 3'b000, 0, 1, 3'b111, 3'b001);
    #1 ck("fwd_br_stall", stall, 1'b0);
    tick();
    ck("fwd_bv", br_valid, 1'b1);
    ck("fwd_bt", br_taken, 1'b1);
    ck("fwd_flags", flags, 3'b001);
    idle();

    // Multi-producer: two Z writers, NE waits for the last one.
    setin(1, 0, 3'd0, 3'b001, 0, 0, 3'b000, 3'b000); tick();
    setin(1, 0, 3'd0, 3'b001, 0, 0, 3'b000, 3'b000); tick();
    setin(1, 1, 3'd0, 3'b000, 0, 1, 3'b001, 3'b001);
    #1 ck("multi_stall1", stall, 1'b1);
    tick();
    setin(1, 1, 3'd0, 3'b000, 0, 1, 3'b001, 3'b000);
    #1 ck("multi_stall0", stall, 1'b0);
    tick();
    ck("multi_bv", br_valid, 1'b1);
    ck("multi_bt", br_taken, 1'b1);
    idle();

    // Independence: N settled at 1, V pending.
    setin(1, 0, 3'd0, 3'b100, 0, 0, 3'b000, 3'b000); tick();
    setin(0, 0, 3'd0, 3'b000, 0, 1, 3'b100, 3'b100); tick();
    setin(1, 0, 3'd0, 3'b010, 0, 0, 3'b000, 3'b000); tick();
    setin(1, 1, 3'd3, 3'b000, 0, 0, 3'b000, 3'b000);
    #1 ck("indep_lt_stall", stall, 1'b0);
    tick();
    ck("indep_lt_bt", br_taken, 1'b1);
    setin(1, 1, 3'd6, 3'b000, 0, 0, 3'b000, 3'b000);
    #1 ck("indep_ov_stall", stall, 1'b1);
    tick(); tick();
    setin(1, 1, 3'd6, 3'b000, 0, 1, 3'b010, 3'b010);
    #1 ck("indep_ov_fwd", stall, 1'b0);
    tick();
    ck("indep_ov_bt", br_taken, 1'b1);
    ck("indep_flags", flags, 3'b110);
    idle();

    // Saturation: fourth Z producer waits for a free slot.
    for (int k = 0; k < 3; k++) begin
      setin(1, 0, 3'd0, 3'b001, 0, 0, 3'b000, 3'b000); tick();
    end
    setin(1, 0, 3'd0, 3'b001, 0, 0, 3'b000, 3'b000);
    #1 ck("sat_stall", stall, 1'b1);
    tick();
    setin(1, 0, 3'd0, 3'b001, 0, 1, 3'b001, 3'b001);
    #1 ck("sat_release", stall, 1'b0);
    tick();
    setin(1, 0, 3'd0, 3'b001, 0, 0, 3'b000, 3'b000);
    #1 ck("sat_still_full", stall, 1'b1);
    setin(0, 0, 3'd0, 3'b000, 1, 0, 3'b000, 3'b000);
    tick();

    // Flush: pend={1,0,2} dropped, GT resolves on stored flags (111).
    setin(1, 0, 3'd0, 3'b101, 0, 0, 3'b000, 3'b000); tick();
    setin(1, 0, 3'd0, 3'b001, 0, 0, 3'b000, 3'b000); tick();
    setin(0, 0, 3'd0, 3'b000, 1, 0, 3'b000, 3'b000); tick();
    ck("flush_flags", flags, 3'b111);
    setin(1, 1, 3'd2, 3'b000, 0, 0, 3'b000, 3'b000);
    #1 ck("flush_gt_stall", stall, 1'b0);
    tick();
    ck("flush_gt_bv", br_valid, 1'b1);
    ck("flush_gt_bt", br_taken, 1'b0);

    // Reset mid-operation with two Z writers outstanding.
    setin(1, 0, 3'd0, 3'b001, 0, 0, 3'b000, 3'b000); tick();
    setin(1, 0, 3'd0, 3'b001, 0, 0, 3'b000, 3'b000); tick();
    setin(1, 1, 3'd7, 3'b000, 0, 0, 3'b000, 3'b000); tick();
    setin(1, 1, 3'd0, 3'b000, 0, 0, 3'b000, 3'b000);
    #1 ck("prerst_stall", stall, 1'b1);
    ck("prerst_bv", br_valid, 1'b1);
    #1 rst = 1'b1;
    model_reset();
    #1 ck("async_rst_flags", flags, 3'b000);
    ck("async_rst_stall", stall, 1'b0);
    ck("async_rst_bv", br_valid, 1'b0);
    #3 rst = 1'b0;
    tick();
    setin(1, 1, 3'd1, 3'b000, 0, 0, 3'b000, 3'b000);
    #1 ck("postrst_eq_stall", stall, 1'b0);
    tick();
    ck("postrst_eq_bv", br_valid, 1'b1);
    ck("postrst_eq_bt", br_taken, 1'b0);
    idle();
    tick();

    // Random traffic: decode holds while stalled, EX retires only pending bits.
    was_stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bit [2:0] avail;
      if (!was_stall) begin
        id_valid = ($urandom_range(0, 3) != 0);
        id_is_branch = ($urandom_range(0, 2) == 0);
        id_ccc = 3'($urandom);
        id_sets = id_is_branch ? 3'b000 : 3'($urandom);
      end
      flush = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < 3; i++) avail[i] = (m_pend[i] > 0);
      ex_mask = 3'($urandom) & avail;
      ex_wr = (ex_mask != 3'b000);
      ex_flags = 3'($urandom);
      #1 was_stall = m_stall();
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
